reply_serializer: RTL



---
 rtl/timetag_pkg.sv | 15 +
 rtl/reply_serializer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/timetag_pkg.sv
// Shared FX2 reply-path definitions: FSM states, reply length,
// checksum seed.
package timetag_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    CKSUM = 2'd2
  } state_t;

  localparam int REPLY_NBYTES = 4;

  localparam logic [7:0] CKSUM_SEED = 8'h00;

endpackage

// File: rtl/reply_serializer.sv
// Streams a captured NBYTES status word to the FX2 host, LSB first.
// Ports: clk, reset (async, active-high), req/req_data (capture
// strobe), busy, req_dropped, reply_rdy/reply/reply_ack/reply_end.
// Option: REPLY_CHECKSUM_EN appends an XOR checksum byte.
module reply_serializer
  import timetag_pkg::*;
#(
  parameter  int NBYTES = REPLY_NBYTES,
  localparam int WIDTH  = 8 * NBYTES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [WIDTH-1:0] req_data,
  output logic             busy,
  output logic             req_dropped,
  output logic             reply_rdy,
  output logic [7:0]       reply,
  input  logic             reply_ack,
  output logic             reply_end
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

`ifdef REPLY_CHECKSUM_EN
  localparam bit PAY_END = 1'b0;
`else
  localparam bit PAY_END = 1'b1;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] sh, sh_n, shifted;
  logic [IW-1:0]    idx, idx_n;
  logic             busy_n, drop_n;
  logic             rdy_n, end_n;
  logic [7:0]       reply_n;
  logic             xfer, last;

`ifdef REPLY_CHECKSUM_EN
  logic [7:0] ck, ck_n;
`endif

  assign xfer    = reply_rdy & reply_ack;
  assign last    = (idx == LAST);
  assign shifted = sh >> 8;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sh          <= '0;
      idx         <= '0;
      busy        <= 1'b0;
      req_dropped <= 1'b0;
      reply_rdy   <= 1'b0;
      reply       <= 8'h00;
      reply_end   <= 1'b0;
`ifdef REPLY_CHECKSUM_EN
      ck          <= CKSUM_SEED;
`endif
    end else begin
      state       <= state_n;
      sh          <= sh_n;
      idx         <= idx_n;
      busy        <= busy_n;
      req_dropped <= drop_n;
      reply_rdy   <= rdy_n;
      reply       <= reply_n;
      reply_end   <= end_n;
`ifdef REPLY_CHECKSUM_EN
      ck          <= ck_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (req) state_n = SEND;
      SEND:
        if (xfer && last) begin
`ifdef REPLY_CHECKSUM_EN
          state_n = CKSUM;
`else
          state_n = IDLE;
`endif
        end
      CKSUM:
        if (xfer) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_comb begin
    sh_n    = sh;
    idx_n   = idx;
    busy_n  = busy;
    rdy_n   = reply_rdy;
    reply_n = reply;
    end_n   = reply_end;
    // busy mirrors "not IDLE", so it also covers the final-ack cycle
    drop_n  = req & busy;
`ifdef REPLY_CHECKSUM_EN
    ck_n    = ck;
`endif
    unique case (state)
      IDLE:
        if (req) begin
          sh_n    = req_data;
          idx_n   = '0;
          busy_n  = 1'b1;
          rdy_n   = 1'b1;
          reply_n = req_data[7:0];
          end_n   = PAY_END && (NBYTES == 1);
`ifdef REPLY_CHECKSUM_EN
          ck_n    = CKSUM_SEED;
`endif
        end
      SEND:
        if (xfer) begin
`ifdef REPLY_CHECKSUM_EN
          ck_n = ck ^ reply;
`endif
          if (!last) begin
            sh_n    = shifted;
            idx_n   = idx + 1'b1;
            reply_n = shifted[7:0];
            end_n   = PAY_END && (idx_n == LAST);
          end else begin
`ifdef REPLY_CHECKSUM_EN
            // checksum folds in the final payload byte
            reply_n = ck ^ reply;
            end_n   = 1'b1;
`else
            busy_n  = 1'b0;
            rdy_n   = 1'b0;
            end_n   = 1'b0;
`endif
          end
        end
      CKSUM:
        if (xfer) begin
          busy_n = 1'b0;
          rdy_n  = 1'b0;
          end_n  = 1'b0;
        end
      default: begin
        busy_n = 1'b0;
        rdy_n  = 1'b0;
        end_n  = 1'b0;
      end
    endcase
  end

endmodule
